// File: rtl/uart_periph.sv
// uart_periph: memory-mapped 8N1 UART with a programmable baud divisor.
// Register offsets (addr[3:0]): 0x4 TXDATA, 0x5 RXDATA, 0x6 STATUS,
// 0x7 CTRL, 0x8 DIV_LO, 0x9 DIV_HI.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   uart_enable         - address-decode select for this block
//   addr, wdata         - byte address and store data
//   write_enable        - store strobe, read_enable - load strobe
//   rdata               - combinational read data (zero-extended byte)
//   tx                  - serial out (idle high), rx - asynchronous serial in
module uart_periph #(
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_enable,
  input  logic [31:0] addr,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  input  logic        rx
);

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 3;

  localparam logic [3:0] OFF_TXDATA = 4'h4;
  localparam logic [3:0] OFF_RXDATA = 4'h5;
  localparam logic [3:0] OFF_STATUS = 4'h6;
  localparam logic [3:0] OFF_CTRL   = 4'h7;
  localparam logic [3:0] OFF_DIV_LO = 4'h8;
  localparam logic [3:0] OFF_DIV_HI = 4'h9;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Bus decode
  logic [3:0] off;
  logic       wr_en;
  logic       rd_en;
  logic       unused_bits;

  assign off         = addr[3:0];
  assign wr_en       = uart_enable & write_enable;
  assign rd_en       = uart_enable & read_enable;
  assign unused_bits = ^{addr[31:4], wdata[31:8]};

  // Divisor registers and derived bit / half-bit periods
  logic [BYTE_W-1:0] div_lo;
  logic [BYTE_W-1:0] div_hi;
  logic [DIV_W-1:0]  div_eff;
  logic [DIV_W-1:0]  div_half;

  assign div_eff  = ({div_hi, div_lo} == '0) ? DIV_W'(1) : {div_hi, div_lo};
  assign div_half = (div_eff < DIV_W'(2)) ? DIV_W'(1) : (div_eff >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_lo <= DEFAULT_DIV[7:0];
      div_hi <= DEFAULT_DIV[15:8];
    end else if (wr_en) begin
      if (off == OFF_DIV_LO) div_lo <= wdata[7:0];
      if (off == OFF_DIV_HI) div_hi <= wdata[7:0];
    end
  end

  // ---------------------------------------------------------------- TX
  logic [1:0]        tx_state,  tx_state_nxt;
  logic [DIV_W-1:0]  tx_cnt,    tx_cnt_nxt;
  logic [DIV_W-1:0]  tx_div,    tx_div_nxt;
  logic [IDX_W-1:0]  tx_idx,    tx_idx_nxt;
  logic [BYTE_W-1:0] tx_shift,  tx_shift_nxt;
  logic              tx_nxt;
  logic              tx_busy,   tx_busy_nxt;
  logic              tx_load_c;

  assign tx_load_c = wr_en && (off == OFF_TXDATA);

  // TX state register
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_div   <= tx_div_nxt;
      tx_idx   <= tx_idx_nxt;
      tx_shift <= tx_shift_nxt;
      tx       <= tx_nxt;
      tx_busy  <= tx_busy_nxt;
    end
  end

  // TX next state; the counter holds the remaining cycles of the current bit
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_div_nxt   = tx_div;
    tx_idx_nxt   = tx_idx;
    tx_shift_nxt = tx_shift;
    tx_nxt       = tx;
    tx_busy_nxt  = tx_busy;
    case (tx_state)
      ST_IDLE: begin
        if (tx_load_c) begin
          tx_state_nxt = ST_START;
          tx_shift_nxt = wdata[7:0];
          tx_div_nxt   = div_eff;
          tx_cnt_nxt   = div_eff - DIV_W'(1);
          tx_nxt       = 1'b0;
          tx_busy_nxt  = 1'b1;
        end
      end
      ST_START: begin
        if (tx_cnt == '0) begin
          tx_state_nxt = ST_DATA;
          tx_cnt_nxt   = tx_div - DIV_W'(1);
          tx_nxt       = tx_shift[0];
          tx_shift_nxt = {1'b0, tx_shift[7:1]};
          tx_idx_nxt   = '0;
        end else begin
          tx_cnt_nxt = tx_cnt - DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_nxt = tx_div - DIV_W'(1);
          if (tx_idx == IDX_W'(7)) begin
            tx_state_nxt = ST_STOP;
            tx_nxt       = 1'b1;
          end else begin
            tx_nxt       = tx_shift[0];
            tx_shift_nxt = {1'b0, tx_shift[7:1]};
            tx_idx_nxt   = tx_idx + IDX_W'(1);
          end
        end else begin
          tx_cnt_nxt = tx_cnt - DIV_W'(1);
        end
      end
      ST_STOP: begin
        if (tx_cnt == '0) begin
          tx_state_nxt = ST_IDLE;
          tx_busy_nxt  = 1'b0;
        end else begin
          tx_cnt_nxt = tx_cnt - DIV_W'(1);
        end
      end
      default: tx_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX
  logic              rx_s1;
  logic              rx_s2;
  logic              rx_d;
  logic              rx_fall_c;
  logic [1:0]        rx_state,  rx_state_nxt;
  logic [DIV_W-1:0]  rx_cnt,    rx_cnt_nxt;
  logic [DIV_W-1:0]  rx_div,    rx_div_nxt;
  logic [IDX_W-1:0]  rx_idx,    rx_idx_nxt;
  logic [BYTE_W-1:0] rx_shift,  rx_shift_nxt;
  logic              rx_done_c;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_overrun;
  logic              frame_error;
  logic              err_clr_c;

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign rx_fall_c = rx_d & ~rx_s2;

  // RX state register
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_div   <= rx_div_nxt;
      rx_idx   <= rx_idx_nxt;
      rx_shift <= rx_shift_nxt;
    end
  end

  // RX next state; the counter holds cycles until the next sample point
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_div_nxt   = rx_div;
    rx_idx_nxt   = rx_idx;
    rx_shift_nxt = rx_shift;
    rx_done_c    = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        if (rx_fall_c) begin
          rx_state_nxt = ST_START;
          rx_div_nxt   = div_eff;
          rx_cnt_nxt   = div_half - DIV_W'(1);
        end
      end
      ST_START: begin
        if (rx_cnt == '0) begin
          // A start bit that reads high at mid-bit was a glitch
          if (!rx_s2) begin
            rx_state_nxt = ST_DATA;
            rx_cnt_nxt   = rx_div - DIV_W'(1);
            rx_idx_nxt   = '0;
          end else begin
            rx_state_nxt = ST_IDLE;
          end
        end else begin
          rx_cnt_nxt = rx_cnt - DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (rx_cnt == '0) begin
          rx_shift_nxt = {rx_s2, rx_shift[7:1]};
          rx_cnt_nxt   = rx_div - DIV_W'(1);
          if (rx_idx == IDX_W'(7)) begin
            rx_state_nxt = ST_STOP;
          end else begin
            rx_idx_nxt = rx_idx + IDX_W'(1);
          end
        end else begin
          rx_cnt_nxt = rx_cnt - DIV_W'(1);
        end
      end
      ST_STOP: begin
        if (rx_cnt == '0) begin
          rx_done_c    = 1'b1;
          rx_state_nxt = ST_IDLE;
        end else begin
          rx_cnt_nxt = rx_cnt - DIV_W'(1);
        end
      end
      default: rx_state_nxt = ST_IDLE;
    endcase
  end

  assign err_clr_c = wr_en && (off == OFF_CTRL) && wdata[0];

  // Receive data and sticky status; a completing byte wins over a read clear
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (rx_done_c) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rd_en && (off == OFF_RXDATA)) begin
        rx_valid <= 1'b0;
      end
      rx_overrun  <= (rx_overrun & ~err_clr_c) | (rx_done_c & rx_valid);
      frame_error <= (frame_error & ~err_clr_c) | (rx_done_c & ~rx_s2);
    end
  end

  // Read mux
  always_comb begin
    rdata = '0;
    if (uart_enable) begin
      case (off)
        OFF_RXDATA: rdata = 32'(rx_data);
        OFF_STATUS: rdata = 32'({4'b0, frame_error, rx_overrun, rx_valid, tx_busy});
        OFF_DIV_LO: rdata = 32'(div_lo);
        OFF_DIV_HI: rdata = 32'(div_hi);
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_periph.sv
// tb_uart_periph: scoreboard bench for uart_periph. Expected TX bits and RX
// bytes are queued when stimulus is driven and popped when the DUT produces
// the corresponding output.
module tb_uart_periph;

  logic        clk = 1'b0;
  logic        reset;
  logic        uart_enable;
  logic [31:0] addr;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        rx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_q[$];
  logic       tx_q[$];

  uart_periph #(.DEFAULT_DIV(16'd434)) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_enable  (uart_enable),
    .addr         (addr),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .wdata        (wdata),
    .rdata        (rdata),
    .tx           (tx),
    .rx           (rx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    uart_enable  = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    addr         = '0;
    wdata        = '0;
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [7:0] data);
    uart_enable  = 1'b1;
    write_enable = 1'b1;
    read_enable  = 1'b0;
    addr         = {28'h0400000, off};
    wdata        = {24'h0, data};
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input logic [3:0] off, output logic [31:0] data);
    uart_enable  = 1'b1;
    write_enable = 1'b0;
    read_enable  = 1'b1;
    addr         = {28'h0400000, off};
    #1 data = rdata;
    tick();
    bus_idle();
  endtask

  // Combinational look at a register without a load strobe
  task automatic peek(input logic [3:0] off, output logic [31:0] data);
    uart_enable  = 1'b1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    addr         = {28'h0400000, off};
    #1 data = rdata;
    uart_enable  = 1'b0;
  endtask

  task automatic push_tx_frame(input logic [7:0] data);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    for (int b = 0; b < 10; b++) tx_q.push_back(frame[b]);
  endtask

  task automatic drive_rx_frame(input logic [7:0] data, input logic stop, input int div);
    logic [9:0] frame;
    frame = {stop, data, 1'b0};
    rx_q.push_back(data);
    for (int b = 0; b < 10; b++) begin
      rx = frame[b];
      repeat (div) tick();
    end
    rx = 1'b1;
  endtask

  // Bounded poll for a STATUS bit; returns ok=0 on timeout
  task automatic wait_status(input int bit_i, input int budget, output bit ok);
    logic [31:0] st;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      peek(4'h6, st);
      if (st[bit_i]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    rx    = 1'b1;
    bus_idle();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    peek(4'h6, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h expected 0", d); end
    peek(4'h5, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_rxdata: got %h expected 0", d); end
    peek(4'h8, d);
    n_checks++;
    if (d !== 32'hB2) begin n_fail++; $display("FAIL reset_div_lo: got %h expected b2", d); end
    peek(4'h9, d);
    n_checks++;
    if (d !== 32'h01) begin n_fail++; $display("FAIL reset_div_hi: got %h expected 01", d); end
    peek(4'h4, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL wo_txdata_read: got %h expected 0", d); end
    addr = 32'h0400_0009;
    uart_enable = 1'b0;
    #1;
    n_checks++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL deselected_rdata: got %h expected 0", rdata); end
    tick();
  endtask

  task automatic test_tx_frame();
    logic [31:0] st;
    logic        expb;
    bus_write(4'h8, 8'h04);
    bus_write(4'h9, 8'h00);
    peek(4'h8, st);
    n_checks++;
    if (st !== 32'h04) begin n_fail++; $display("FAIL div_lo_write: got %h expected 04", st); end
    tick();
    push_tx_frame(8'hA5);
    bus_write(4'h4, 8'hA5);
    for (int b = 0; b < 10; b++) begin
      expb = tx_q.pop_front();
      for (int c = 0; c < 4; c++) begin
        peek(4'h6, st);
        n_checks++;
        if (tx !== expb || st[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL tx_a5 bit%0d cyc%0d: got tx=%b busy=%b expected tx=%b busy=1", b, c, tx, st[0], expb);
        end
        tick();
      end
    end
    peek(4'h6, st);
    n_checks++;
    if (tx !== 1'b1 || st !== 32'h0) begin
      n_fail++; $display("FAIL tx_a5_end: got tx=%b status=%h expected tx=1 status=0", tx, st);
    end
  endtask

  task automatic test_tx_busy_ignore();
    logic [31:0] st;
    logic        expb;
    bit          ok;
    tick();
    push_tx_frame(8'h5A);
    bus_write(4'h4, 8'h5A);
    for (int k = 0; k < 40; k++) begin
      if (k % 4 == 0) expb = tx_q.pop_front();
      n_checks++;
      if (tx !== expb) begin
        n_fail++; $display("FAIL tx_busy_ignore k%0d: got %b expected %b", k, tx, expb);
      end
      if (k == 6) begin
        uart_enable  = 1'b1;
        write_enable = 1'b1;
        addr         = 32'h0400_0004;
        wdata        = 32'hFF;
      end else begin
        bus_idle();
      end
      tick();
    end
    ok = 1'b1;
    repeat (12) begin
      if (tx !== 1'b1) ok = 1'b0;
      tick();
    end
    peek(4'h6, st);
    n_checks++;
    if (!ok || st !== 32'h0) begin
      n_fail++; $display("FAIL tx_after_ignored: got idle_ok=%b status=%h expected 1 and 0", ok, st);
    end
  endtask

  task automatic test_rx_frame();
    logic [31:0] d;
    logic [7:0]  exp;
    bit          ok;
    tick();
    drive_rx_frame(8'h3C, 1'b1, 4);
    wait_status(1, 20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rx_3c_timeout: got no rx_valid expected rx_valid=1"); end
    bus_read(4'h6, d);
    n_checks++;
    if (d !== 32'h02) begin n_fail++; $display("FAIL rx_3c_status: got %h expected 02", d); end
    exp = rx_q.pop_front();
    bus_read(4'h5, d);
    n_checks++;
    if (d !== {24'h0, exp}) begin n_fail++; $display("FAIL rx_3c_data: got %h expected %h", d, exp); end
    bus_read(4'h6, d);
    n_checks++;
    if (d !== 32'h00) begin n_fail++; $display("FAIL rx_3c_status_after_read: got %h expected 00", d); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    logic [7:0]  exp;
    bit          ok;
    tick();
    drive_rx_frame(8'h11, 1'b1, 4);
    wait_status(1, 20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rx_11_timeout: got no rx_valid expected rx_valid=1"); end
    repeat (2) tick();
    drive_rx_frame(8'h22, 1'b1, 4);
    wait_status(2, 20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rx_22_timeout: got no overrun expected overrun=1"); end
    void'(rx_q.pop_front());
    exp = rx_q.pop_front();
    peek(4'h6, d);
    n_checks++;
    if (d !== 32'h06) begin n_fail++; $display("FAIL overrun_status: got %h expected 06", d); end
    peek(4'h5, d);
    n_checks++;
    if (d !== {24'h0, exp}) begin n_fail++; $display("FAIL overrun_data: got %h expected %h", d, exp); end
    tick();
    bus_write(4'h7, 8'h01);
    peek(4'h6, d);
    n_checks++;
    if (d !== 32'h02) begin n_fail++; $display("FAIL ctrl_clear_status: got %h expected 02", d); end
    tick();
    bus_read(4'h5, d);
    peek(4'h6, d);
    n_checks++;
    if (d !== 32'h00) begin n_fail++; $display("FAIL overrun_final_status: got %h expected 00", d); end
  endtask

  task automatic test_rx_errors();
    logic [31:0] d;
    logic [7:0]  exp;
    bit          ok;
    tick();
    drive_rx_frame(8'h81, 1'b0, 4);
    wait_status(1, 20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rx_ferr_timeout: got no rx_valid expected rx_valid=1"); end
    peek(4'h6, d);
    n_checks++;
    if (d !== 32'h0A) begin n_fail++; $display("FAIL ferr_status: got %h expected 0a", d); end
    exp = rx_q.pop_front();
    tick();
    bus_read(4'h5, d);
    n_checks++;
    if (d !== {24'h0, exp}) begin n_fail++; $display("FAIL ferr_data: got %h expected %h", d, exp); end
    bus_write(4'h7, 8'h01);
    peek(4'h6, d);
    n_checks++;
    if (d !== 32'h00) begin n_fail++; $display("FAIL ferr_cleared: got %h expected 00", d); end
    tick();
    rx = 1'b0;
    tick();
    rx = 1'b1;
    repeat (60) tick();
    peek(4'h6, d);
    n_checks++;
    if (d !== 32'h00) begin n_fail++; $display("FAIL glitch_status: got %h expected 00", d); end
    peek(4'h5, d);
    n_checks++;
    if (d !== {24'h0, exp}) begin n_fail++; $display("FAIL glitch_data: got %h expected %h", d, exp); end
  endtask

  task automatic test_div_one();
    logic [31:0] st;
    logic        expb;
    tick();
    bus_write(4'h8, 8'h00);
    bus_write(4'h9, 8'h00);
    push_tx_frame(8'hC3);
    bus_write(4'h4, 8'hC3);
    for (int b = 0; b < 10; b++) begin
      expb = tx_q.pop_front();
      peek(4'h6, st);
      n_checks++;
      if (tx !== expb || st[0] !== 1'b1) begin
        n_fail++; $display("FAIL div1_bit%0d: got tx=%b busy=%b expected tx=%b busy=1", b, tx, st[0], expb);
      end
      tick();
    end
    peek(4'h6, st);
    n_checks++;
    if (tx !== 1'b1 || st !== 32'h0) begin
      n_fail++; $display("FAIL div1_end: got tx=%b status=%h expected tx=1 status=0", tx, st);
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] d;
    bit          ok;
    tick();
    bus_write(4'h8, 8'h04);
    bus_write(4'h9, 8'h00);
    drive_rx_frame(8'h55, 1'b1, 4);
    wait_status(1, 20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rx_55_timeout: got no rx_valid expected rx_valid=1"); end
    tick();
    bus_write(4'h4, 8'hF0);
    repeat (10) tick();
    n_checks++;
    if (tx !== 1'b0) begin n_fail++; $display("FAIL midtx_bit: got %b expected 0", tx); end
    reset = 1'b1;
    tick();
    rx_q.delete();
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL midtx_reset_tx: got %b expected 1", tx); end
    peek(4'h6, d);
    n_checks++;
    if (d !== 32'h00) begin n_fail++; $display("FAIL midtx_reset_status: got %h expected 00", d); end
    peek(4'h5, d);
    n_checks++;
    if (d !== 32'h00) begin n_fail++; $display("FAIL midtx_reset_rxdata: got %h expected 00", d); end
    reset = 1'b0;
    tick();
    peek(4'h8, d);
    n_checks++;
    if (d !== 32'hB2) begin n_fail++; $display("FAIL midtx_div_lo: got %h expected b2", d); end
    peek(4'h9, d);
    n_checks++;
    if (d !== 32'h01) begin n_fail++; $display("FAIL midtx_div_hi: got %h expected 01", d); end
    ok = 1'b1;
    repeat (50) begin
      if (tx !== 1'b1) ok = 1'b0;
      tick();
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midtx_no_resume: got tx activity expected tx held 1"); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_tx_frame();
    test_tx_busy_ignore();
    test_rx_frame();
    test_rx_overrun();
    test_rx_errors();
    test_div_one();
    test_reset_mid_tx();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_periph.md
UART_PERIPH -- requirements
Module: uart_periph

Interface
REQ-001 SHALL have parameter DEFAULT_DIV, default 16'd434, the reset value of the baud divisor in clk cycles per bit.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port uart_enable, input, 1, address-decode select, asserted for addr 0x04000004..0x04000009.
REQ-005 SHALL have port addr, input, 32, byte address; only addr[3:0] is used inside the block.
REQ-006 SHALL have port write_enable, input, 1, store strobe, qualified by uart_enable.
REQ-007 SHALL have port read_enable, input, 1, load strobe, qualified by uart_enable.
REQ-008 SHALL have port wdata, input, 32, store data; only wdata[7:0] is used.
REQ-009 SHALL have port rdata, output, 32, combinational read data: register byte zero-extended, 0 when uart_enable=0.
REQ-010 SHALL have port tx, output, 1, serial out; idle high.
REQ-011 SHALL have port rx, input, 1, asynchronous serial in.

Function
REQ-012 SHALL map registers as: 0x4 TXDATA (W), 0x5 RXDATA (R), 0x6 STATUS (R), 0x7 CTRL (W), 0x8 DIV_LO (R/W), 0x9 DIV_HI (R/W).
REQ-013 SHALL define STATUS as bit0 tx_busy, bit1 rx_valid, bit2 rx_overrun, bit3 frame_error, bits7:4 zero.
REQ-014 SHALL clear rx_overrun and frame_error on a CTRL write with wdata[0]=1; all other CTRL bits are ignored.
REQ-015 SHALL use an effective bit period div_eff = max(DIV,1) cycles, with DIV = {DIV_HI,DIV_LO}.
REQ-016 SHALL use 8N1 framing, LSB first: one start bit (0), 8 data bits, one stop bit (1).
REQ-017 SHALL implement the TX FSM with states IDLE, START, DATA, STOP.
REQ-018 SHALL on a TXDATA write in IDLE latch wdata[7:0] and div_eff, drive tx low on the next edge, and set tx_busy the same edge.
REQ-019 SHALL hold each TX bit exactly div_eff cycles, then return to IDLE after STOP and clear tx_busy; one frame totals 10*div_eff cycles.
REQ-020 SHALL ignore a TXDATA write while tx_busy=1 (no queueing).
REQ-021 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-022 SHALL implement the RX FSM with states IDLE, START, DATA, STOP.
REQ-023 SHALL start RX on a synchronized 1->0 transition in IDLE and latch div_eff at that point.
REQ-024 SHALL resample after div_eff/2 cycles (integer floor, minimum 1) and return to IDLE without effect if the start bit reads high.
REQ-025 SHALL then sample each data bit and the stop bit at div_eff-cycle intervals.
REQ-026 SHALL on STOP sample load RXDATA and set rx_valid; if the stop bit is 0, additionally set frame_error (byte still stored).
REQ-027 SHALL set rx_overrun when a byte completes while rx_valid=1; the new byte overwrites RXDATA.
REQ-028 SHALL clear rx_valid on a RXDATA read, except when a byte completes in the same cycle (the new byte is stored and rx_valid stays 1).
REQ-029 SHALL give DIV writes effect on the next frame only; frames in progress keep their latched divisor.
REQ-030 SHALL have no side effects for reads of STATUS, DIV_LO, or DIV_HI, nor for writes to read-only offsets or reads of write-only offsets (rdata=0 for the latter).

Reset
REQ-031 SHALL on reset put both FSMs in IDLE and drive tx=1, tx_busy=0, rx_valid=0, rx_overrun=0, frame_error=0, RXDATA=0, DIV=DEFAULT_DIV, and set synchronizer flops to 1.
REQ-032 SHALL abort any frame in progress when reset is asserted, with tx high on the first edge in which reset is sampled.

Verification
REQ-033 SHALL cover: DIV=4, write TXDATA 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, tx_busy high for 40 cycles.
REQ-034 SHALL cover: DIV=4, drive rx frame 0x3C with a valid stop bit -> STATUS=0x02, RXDATA read=0x3C, then STATUS=0x00.
REQ-035 SHALL cover: receive two bytes 0x11 then 0x22 with no read in between -> RXDATA=0x22, STATUS=0x06; CTRL write 0x01 -> STATUS=0x02.
REQ-036 SHALL cover: rx stop bit held 0 -> frame_error=1, rx_valid=1; a 1-cycle low glitch on rx -> no byte received.
REQ-037 SHALL cover: TXDATA write while busy -> original frame unaltered; reset asserted mid-TX -> tx=1 and STATUS=0x00 on the next edge.
REQ-038 SHALL cover: DIV_LO=0, DIV_HI=0 -> 1-cycle bits; DIV readback after reset -> 0xB2 at 0x8, 0x01 at 0x9.
